us_timer: RTL and testbench
===========================

# us_timer

Programmable microsecond timer that consumes the 1 MHz divided clock produced by the upstream clock-divider stage. The 1 MHz signal is sampled as data in the system clock domain and turned into single-cycle tick strobes. The block counts those ticks down from a loaded period and raises a one-cycle `done` pulse on expiry, in one-shot or auto-reload mode. It serves as the timebase for delays and periodic events in the design.

## Interface
- `CNT_W`, default 16: width of the period and remaining-count registers, in ticks (µs).
- `clk`, in, 1: system clock (100 MHz); all logic on its rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `clk_1mhz`, in, 1: divided clock from the upstream divider, sampled as data.
- `start`, in, 1: single-cycle request to load `period` and `mode` and begin counting.
- `stop`, in, 1: single-cycle abort.
- `mode`, in, 1: 0 = one-shot, 1 = periodic (auto-reload). Latched on accepted `start`.
- `period`, in, CNT_W: tick count. Latched on accepted `start`.
- `busy`, out, 1: timer running.
- `done`, out, 1: one-cycle expiry pulse.
- `remain`, out, CNT_W: ticks remaining in the current period.

## Operation
- Tick generation
  - `tick` = rising edge of the sampled `clk_1mhz`: current sample is 1 and the previous-sample register is 0.
  - The previous-sample register resets to 1, so no spurious tick occurs right after reset.
- The FSM has two states, IDLE and RUN. Reset forces IDLE.
- IDLE:
  - `start` with `period` ≠ 0: latch `period` and `mode`, set `remain` = `period`, go to RUN.
  - `start` with `period` = 0 is ignored, with no `done`.
  - Ticks are ignored.
- RUN, on a tick:
  - `remain` > 1: decrement `remain`.
  - `remain` = 1: pulse `done`.
    - Periodic mode: reload `remain` from the latched period and stay in RUN.
    - One-shot mode: set `remain` = 0 and go to IDLE.
- RUN, on `start` with `period` ≠ 0: restart by re-latching `period` and `mode` and reloading `remain`. No `done`, even if a final tick coincides.
- RUN, on `stop`: go to IDLE, `remain` = 0, no `done`.
- Priority when inputs coincide: `stop` > `start` > tick.
- `busy` = 1 exactly when the state is RUN.
- `remain` never underflows or wraps. Any `period` from 1 to 2^CNT_W−1 is legal.
- Changes to `period` or `mode` outside an accepted `start` have no effect.

## Timing
- Reset values: `busy` = 0, `done` = 0, `remain` = 0, state IDLE, sample registers 0, previous-sample register 1.
- Reset asserted mid-count returns every output to its reset value immediately, with no `done`.
- Start latency: `start` sampled at edge N gives `busy` = 1 and `remain` = `period` after edge N.
- Tick latency without the macro: tick is asserted in the first `clk` cycle in which `clk_1mhz` = 1 after being 0.
- Expiry latency: `done` rises on the edge that samples the final tick and lasts exactly one cycle.
  - One-shot: `busy` falls on that same edge.
  - Periodic: expiries are spaced exactly `period` × 100 clk cycles apart.
- First expiry: `done` fires on the `period`-th tick after the accepted start. A tick coincident with the `start` cycle is not counted.
- Every output is registered; there are no combinational input-to-output paths.

## Configuration
- `US_TIMER_SYNC_EN`
  - Defined: `clk_1mhz` passes through a two-flop synchronizer (both stages reset to 0) before edge detection. Tick and `done` shift 2 cycles later. This makes the input safe when driven from an unrelated clock.
  - Undefined: `clk_1mhz` feeds the edge detector directly, which is legal only because the upstream divider shares `clk`.
  - The FSM and counter behaviour are identical in both builds.

## Test plan
- Reset and tick: hold `rst` = 1 while driving `clk_1mhz` at 50 cycles high / 50 low; release `rst` -> `busy` = 0, `remain` = 0, `done` never pulses.
- One-shot: `start` with `period` = 5, `mode` = 0 -> `remain` steps 5→4→3→2→1 on successive ticks; a single `done` on the 5th tick; `busy` = 0 and `remain` = 0 afterwards.
- Periodic: `period` = 3, `mode` = 1, run 10 ticks -> `done` on ticks 3, 6 and 9, spaced 300 clk cycles apart; `busy` stays 1.
- Abort and priority:
  - `stop` when `remain` = 2 -> IDLE, `remain` = 0, no `done`.
  - `stop` and the final tick in the same cycle -> no `done`.
  - `start` (`period` = 4) on the final tick of a run -> no `done`; `remain` = 4.
- Zero period and asynchronous reset:
  - `start` with `period` = 0 -> `busy` stays 0.
  - `rst` pulse in mid-cycle at `remain` = 7 -> outputs clear immediately, without waiting for a clock edge.
- Width boundary: `CNT_W` = 4, `period` = 15 -> `done` after exactly 15 ticks; `remain` never wraps past 0.
- Build check: repeat the one-shot scenario with `US_TIMER_SYNC_EN` defined -> `done` occurs exactly 2 cycles later than in the undefined build.

Source files
------------

// File: rtl/us_timer_if.sv
// Control/status bundle for us_timer: requests from the master, status back from the timer.
interface us_timer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             stop;
  logic             mode;
  logic [CNT_W-1:0] period;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] remain;

  modport master (
    output start, stop, mode, period,
    input  busy, done, remain
  );

  modport slave (
    input  start, stop, mode, period,
    output busy, done, remain
  );
endinterface

// File: rtl/us_timer.sv
// Microsecond down-counter driven by rising edges of the 1 MHz divider output.
// Define US_TIMER_SYNC_EN to insert a two-flop synchronizer ahead of the edge detector.
module us_timer #(
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_1mhz,
  us_timer_if.slave  tmr
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic sample;
  logic sample_prev_reg;
  logic tick;

`ifdef US_TIMER_SYNC_EN
  localparam int SYNC_STAGES = 2;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_head
        assign sync_next[gi] = clk_1mhz;
      end else begin : g_tail
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= sync_next;
    end
  end

  assign sample = sync_reg[SYNC_STAGES-1];
`else
  // Divider shares clk, so its output is already a clean synchronous level.
  assign sample = clk_1mhz;
`endif

  // Previous sample starts high so a level already high at reset release is not a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_prev_reg <= 1'b1;
    end else begin
      sample_prev_reg <= sample;
    end
  end

  assign tick = sample & ~sample_prev_reg;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] remain_reg, remain_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic             mode_reg, mode_next;
  logic             done_reg, done_next;
  logic             start_ok;

  assign start_ok = tmr.start && (tmr.period != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      remain_reg <= '0;
      period_reg <= '0;
      mode_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      remain_reg <= remain_next;
      period_reg <= period_next;
      mode_reg   <= mode_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    remain_next = remain_reg;
    period_next = period_reg;
    mode_next   = mode_reg;
    done_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!tmr.stop && start_ok) begin
          period_next = tmr.period;
          mode_next   = tmr.mode;
          remain_next = tmr.period;
          state_next  = RUN;
        end
      end

      RUN: begin
        if (tmr.stop) begin
          remain_next = '0;
          state_next  = IDLE;
        end else if (start_ok) begin
          // Restart swallows a coincident final tick, so no done here.
          period_next = tmr.period;
          mode_next   = tmr.mode;
          remain_next = tmr.period;
        end else if (tick) begin
          if (remain_reg > ONE) begin
            remain_next = remain_reg - ONE;
          end else begin
            done_next = 1'b1;
            if (mode_reg) begin
              remain_next = period_reg;
            end else begin
              remain_next = '0;
              state_next  = IDLE;
            end
          end
        end
      end
    endcase
  end

  assign tmr.busy   = (state_reg == RUN);
  assign tmr.done   = done_reg;
  assign tmr.remain = remain_reg;

endmodule

// File: tb/tb_us_timer.sv
// Scoreboard bench for us_timer: expected done cycles are queued at start and matched on each done pulse.
module tb_us_timer;

`ifdef US_TIMER_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_1mhz = 1'b0;

  us_timer_if #(.CNT_W(16)) tif ();
  us_timer_if #(.CNT_W(4))  tif4 ();

  us_timer #(.CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .clk_1mhz (clk_1mhz),
    .tmr      (tif)
  );

  us_timer #(.CNT_W(4)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .clk_1mhz (clk_1mhz),
    .tmr      (tif4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 1 MHz source: 50 cycles high / 50 low, changing on the falling edge of clk.
  int phase = 99;
  int tick_base = 0;
  always @(negedge clk) begin
    phase = (phase + 1) % 100;
    clk_1mhz = (phase < 50);
    if (phase == 0) tick_base = cyc + 1 + SYNC_LAT;
  end

  int n_compared = 0;
  int n_mismatched = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_compared++;
    if (got != exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  int dq[$];
  int dq4[$];

  always @(negedge clk) begin
    int e;
    if (tif.done) begin
      $display("txn: dut done at cycle %0d", cyc);
      if (dq.size() == 0) begin
        check_val("done_unexpected", int'(tif.done), 0);
      end else begin
        e = dq.pop_front();
        check_val("done_cycle", cyc, e);
      end
    end
    if (tif4.done) begin
      $display("txn: dut4 done at cycle %0d", cyc);
      if (dq4.size() == 0) begin
        check_val("done4_unexpected", int'(tif4.done), 0);
      end else begin
        e = dq4.pop_front();
        check_val("done4_cycle", cyc, e);
      end
    end
  end

  function automatic int next_tick_after(input int s);
    int d;
    d = ((s - tick_base) % 100 + 100) % 100;
    return s + 100 - d;
  endfunction

  // Leaves us at a falling edge whose following rising edge sits 'off' cycles after a tick edge.
  task automatic go_off(input int off);
    @(negedge clk);
    while ((((cyc + 1 - tick_base) % 100) + 100) % 100 != off) @(negedge clk);
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  // Drives a one-cycle start; s is the clk edge that samples it. Returns at that edge's falling edge.
  task automatic do_start(input bit sel4, input int per, input bit md, output int s);
    if (sel4) begin
      tif4.start = 1'b1; tif4.period = 4'(per); tif4.mode = md;
    end else begin
      tif.start = 1'b1; tif.period = 16'(per); tif.mode = md;
    end
    s = cyc + 1;
    $display("txn: start sel4=%0d period=%0d mode=%0d at edge %0d", sel4, per, md, s);
    @(negedge clk);
    // Scramble inputs afterwards; the latched values must not follow them.
    tif.start = 1'b0; tif.period = 16'hBEEF; tif.mode = ~md;
    tif4.start = 1'b0; tif4.period = 4'hA; tif4.mode = ~md;
  endtask

  task automatic pulse_stop();
    tif.stop = 1'b1;
    @(negedge clk);
    tif.stop = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, s2, t1, t2;
    tif.start = 1'b0; tif.stop = 1'b0; tif.mode = 1'b0; tif.period = '0;
    tif4.start = 1'b0; tif4.stop = 1'b0; tif4.mode = 1'b0; tif4.period = '0;
    rst = 1'b1;

    // Reset held while the 1 MHz source toggles
    repeat (250) @(negedge clk);
    check_val("rst_busy", int'(tif.busy), 0);
    check_val("rst_remain", int'(tif.remain), 0);
    check_val("rst_done", int'(tif.done), 0);
    rst = 1'b0;
    repeat (250) @(negedge clk);
    check_val("post_rst_busy", int'(tif.busy), 0);
    check_val("post_rst_remain", int'(tif.remain), 0);

    // One-shot, period 5
    go_off(37);
    do_start(1'b0, 5, 1'b0, s);
    check_val("os_start_busy", int'(tif.busy), 1);
    check_val("os_start_remain", int'(tif.remain), 5);
    t1 = next_tick_after(s);
    dq.push_back(t1 + 400);
    for (int k = 1; k <= 4; k++) begin
      wait_edge(t1 + (k - 1) * 100);
      check_val("os_remain", int'(tif.remain), 5 - k);
      check_val("os_busy", int'(tif.busy), 1);
    end
    wait_edge(t1 + 400);
    check_val("os_end_busy", int'(tif.busy), 0);
    check_val("os_end_remain", int'(tif.remain), 0);

    // Periodic, period 3, ten ticks
    go_off(60);
    do_start(1'b0, 3, 1'b1, s);
    t1 = next_tick_after(s);
    dq.push_back(t1 + 200);
    dq.push_back(t1 + 500);
    dq.push_back(t1 + 800);
    wait_edge(t1 + 200);
    check_val("per_reload_remain", int'(tif.remain), 3);
    check_val("per_reload_busy", int'(tif.busy), 1);
    wait_edge(t1 + 900);
    check_val("per_t10_remain", int'(tif.remain), 2);
    check_val("per_t10_busy", int'(tif.busy), 1);
    pulse_stop();
    check_val("per_stop_busy", int'(tif.busy), 0);
    check_val("per_stop_remain", int'(tif.remain), 0);
    repeat (200) @(negedge clk);

    // Stop at remain = 2
    go_off(20);
    do_start(1'b0, 4, 1'b0, s);
    t1 = next_tick_after(s);
    wait_edge(t1 + 100);
    check_val("stop2_remain_before", int'(tif.remain), 2);
    pulse_stop();
    check_val("stop2_busy", int'(tif.busy), 0);
    check_val("stop2_remain", int'(tif.remain), 0);
    wait_edge(t1 + 400);

    // Stop (with a competing start) on the final tick
    go_off(20);
    do_start(1'b0, 2, 1'b0, s);
    t1 = next_tick_after(s);
    wait_edge(t1 + 99);
    check_val("stopfin_remain_before", int'(tif.remain), 1);
    tif.stop = 1'b1; tif.start = 1'b1; tif.period = 16'd4;
    @(negedge clk);
    tif.stop = 1'b0; tif.start = 1'b0;
    check_val("stopfin_busy", int'(tif.busy), 0);
    check_val("stopfin_remain", int'(tif.remain), 0);
    repeat (300) @(negedge clk);

    // Restart with period 4 on the final tick
    go_off(20);
    do_start(1'b0, 2, 1'b0, s);
    t1 = next_tick_after(s);
    wait_edge(t1 + 99);
    do_start(1'b0, 4, 1'b0, s2);
    check_val("restart_edge", s2, t1 + 100);
    check_val("restart_remain", int'(tif.remain), 4);
    check_val("restart_busy", int'(tif.busy), 1);
    t2 = next_tick_after(s2);
    dq.push_back(t2 + 300);
    wait_edge(t2 + 300);
    check_val("restart_end_busy", int'(tif.busy), 0);
    check_val("restart_end_remain", int'(tif.remain), 0);

    // Zero period is ignored
    go_off(50);
    do_start(1'b0, 0, 1'b0, s);
    check_val("zero_busy", int'(tif.busy), 0);
    check_val("zero_remain", int'(tif.remain), 0);
    repeat (250) @(negedge clk);
    check_val("zero_busy_late", int'(tif.busy), 0);

    // Asynchronous reset mid-cycle at remain = 7
    go_off(10);
    do_start(1'b0, 9, 1'b0, s);
    t1 = next_tick_after(s);
    wait_edge(t1 + 100);
    check_val("arst_remain_before", int'(tif.remain), 7);
    #2 rst = 1'b1;
    #1;
    check_val("arst_busy", int'(tif.busy), 0);
    check_val("arst_remain", int'(tif.remain), 0);
    check_val("arst_done", int'(tif.done), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_edge(t1 + 900);
    check_val("arst_busy_late", int'(tif.busy), 0);

    // Width boundary: 4-bit counter, period 15
    go_off(45);
    do_start(1'b1, 15, 1'b0, s);
    check_val("w4_start_busy", int'(tif4.busy), 1);
    check_val("w4_start_remain", int'(tif4.remain), 15);
    t1 = next_tick_after(s);
    dq4.push_back(t1 + 1400);
    wait_edge(t1 + 1300);
    check_val("w4_remain_t14", int'(tif4.remain), 1);
    wait_edge(t1 + 1400);
    check_val("w4_end_remain", int'(tif4.remain), 0);
    check_val("w4_end_busy", int'(tif4.busy), 0);
    wait_edge(t1 + 1600);
    check_val("w4_no_wrap", int'(tif4.remain), 0);

    repeat (5) @(negedge clk);
    check_val("dq_left", dq.size(), 0);
    check_val("dq4_left", dq4.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
